biriscv_mem_arbiter: RTL and testbench

//  N-port round-robin arbiter in front of an internal single-port word RAM with byte strobes.

---
 rtl/biriscv_mem_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_biriscv_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/biriscv_mem_arbiter.sv
// biriscv_mem_arbiter
// Round-robin arbiter that shares one single-port, byte-strobed word RAM
// between NUM_PORTS requestors. Each port has its own req/gnt/rvalid handshake.
// Every granted access returns exactly one response, LATENCY cycles after the
// grant edge. Addresses beyond the RAM return an error response. A free-running
// counter tracks how many cycles saw contention.
//
// Parameter ranges: NUM_PORTS 1..8, LATENCY 1..4, DATA_WIDTH a multiple of 8,
// and ADDR_WIDTH small enough that the word index fits below address bit 32.

module biriscv_mem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_PORTS-1:0]                req_i,
  input  logic [NUM_PORTS-1:0]                we_i,
  input  logic [NUM_PORTS*32-1:0]             addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     wdata_i,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] be_i,
  output logic [NUM_PORTS-1:0]                gnt_o,
  output logic [NUM_PORTS-1:0]                rvalid_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]     rdata_o,
  output logic [NUM_PORTS-1:0]                err_o,
  output logic [31:0]                         conflict_o
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int DEPTH    = 1 << ADDR_WIDTH;
  // The pointer starts on the last port, so port 0 is searched first after reset.
  localparam logic [PW-1:0] LAST_RST = PW'(NUM_PORTS - 1);

  // Round-robin state and contention counter
  logic [PW-1:0]         last_q, last_d;
  logic [31:0]           conflict_q, conflict_d;
  logic [3:0]            req_cnt_s;

  // Arbitration result for the current cycle
  logic                  found_s;
  logic [PW-1:0]         gidx_s;
  logic [NUM_PORTS-1:0]  onehot_s;
  logic                  xfer_s;

  // Request fields of the granted port
  logic [31:0]           sel_addr_s;
  logic                  sel_we_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic [BE_WIDTH-1:0]   sel_be_s;
  logic                  oor_s;
  logic [ADDR_WIDTH-1:0] widx_s;
  logic                  ram_wr_s, ram_rd_s;

  // Word RAM and its read register
  logic [DATA_WIDTH-1:0] ram_q [DEPTH];
  logic [DATA_WIDTH-1:0] ram_rdata_q;

  // Response pipeline: stage 0 is loaded on the grant edge, and the last stage drives the outputs
  logic                  pv_q [LATENCY];
  logic                  pv_d [LATENCY];
  logic [PW-1:0]         pp_q [LATENCY];
  logic [PW-1:0]         pp_d [LATENCY];
  logic                  pe_q [LATENCY];
  logic                  pe_d [LATENCY];
  logic [DATA_WIDTH-1:0] last_data_s;

  // Search the ports in order last+1, last+2, ... and pick the first one that is requesting
  always_comb begin
    found_s = 1'b0;
    gidx_s  = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      if (!found_s && req_i[PW'((int'(last_q) + i) % NUM_PORTS)]) begin
        found_s = 1'b1;
        gidx_s  = PW'((int'(last_q) + i) % NUM_PORTS);
      end else begin
        gidx_s  = gidx_s;
      end
    end
    onehot_s = found_s ? (NUM_PORTS'(1) << gidx_s) : '0;
    xfer_s   = found_s & ~rst_i;
  end

  // No grant is shown while reset is held
  assign gnt_o = rst_i ? '0 : onehot_s;

  // Route the granted port's request fields through a one-hot AND-OR mux
  always_comb begin
    sel_addr_s  = '0;
    sel_we_s    = 1'b0;
    sel_wdata_s = '0;
    sel_be_s    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      sel_addr_s  = sel_addr_s  | (addr_i[p*32 +: 32] & {32{onehot_s[p]}});
      sel_we_s    = sel_we_s    | (we_i[p] & onehot_s[p]);
      sel_wdata_s = sel_wdata_s | (wdata_i[p*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{onehot_s[p]}});
      sel_be_s    = sel_be_s    | (be_i[p*BE_WIDTH +: BE_WIDTH] & {BE_WIDTH{onehot_s[p]}});
    end
  end

  // Word decode: byte-offset bits are ignored, and any set bit above the RAM range is an error
  always_comb begin
    oor_s    = ((sel_addr_s >> (ADDR_WIDTH + 2)) != 32'd0);
    widx_s   = sel_addr_s[ADDR_WIDTH+1:2];
    ram_wr_s = xfer_s & sel_we_s & ~oor_s;
    ram_rd_s = xfer_s & ~sel_we_s & ~oor_s;
  end

  // Single-port RAM: byte-strobed write plus a registered read, kept together so it maps to a RAM macro. Contents survive reset.
  always_ff @(posedge clk_i) begin
    if (ram_wr_s) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (sel_be_s[b]) begin
          ram_q[widx_s][b*8 +: 8] <= sel_wdata_s[b*8 +: 8];
        end
      end
    end
    if (rst_i) begin
      ram_rdata_q <= '0;
    end else if (ram_rd_s) begin
      ram_rdata_q <= ram_q[widx_s];
    end else begin
      ram_rdata_q <= '0;
    end
  end

  // Next state of the {valid, port, err} pipeline; a new entry enters only on a real transfer
  always_comb begin
    pv_d[0] = xfer_s;
    pp_d[0] = gidx_s;
    pe_d[0] = xfer_s & oor_s;
    for (int k = 1; k < LATENCY; k++) begin
      pv_d[k] = pv_q[k-1];
      pp_d[k] = pp_q[k-1];
      pe_d[k] = pe_q[k-1];
    end
  end

  // Advance the pipeline; reset drops every in-flight response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < LATENCY; k++) begin
        pv_q[k] <= 1'b0;
        pp_q[k] <= '0;
        pe_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < LATENCY; k++) begin
        pv_q[k] <= pv_d[k];
        pp_q[k] <= pp_d[k];
        pe_q[k] <= pe_d[k];
      end
    end
  end

  // The RAM read register is the first data stage; further stages keep data aligned with valid
  generate
    if (LATENCY > 1) begin : g_dpipe
      logic [DATA_WIDTH-1:0] dpipe_q [LATENCY-1];
      logic [DATA_WIDTH-1:0] dpipe_d [LATENCY-1];

      // Shift read data one stage per cycle
      always_comb begin
        dpipe_d[0] = ram_rdata_q;
        for (int k = 1; k < LATENCY - 1; k++) begin
          dpipe_d[k] = dpipe_q[k-1];
        end
      end

      // Data stage registers, cleared on reset so outputs are deterministic
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int k = 0; k < LATENCY - 1; k++) begin
            dpipe_q[k] <= '0;
          end
        end else begin
          for (int k = 0; k < LATENCY - 1; k++) begin
            dpipe_q[k] <= dpipe_d[k];
          end
        end
      end

      assign last_data_s = dpipe_q[LATENCY-2];
    end else begin : g_dnopipe
      assign last_data_s = ram_rdata_q;
    end
  endgenerate

  // Steer the last pipeline stage onto its port; idle ports read back zero
  always_comb begin
    rvalid_o = '0;
    err_o    = '0;
    rdata_o  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (pv_q[LATENCY-1] && (pp_q[LATENCY-1] == PW'(p))) begin
        rvalid_o[p]                         = 1'b1;
        err_o[p]                            = pe_q[LATENCY-1];
        rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = last_data_s;
      end else begin
        rvalid_o[p]                         = 1'b0;
        err_o[p]                            = 1'b0;
        rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end

  // Pointer update on a transfer, and contention counting (two or more requests)
  always_comb begin
    req_cnt_s = 4'd0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      req_cnt_s = req_cnt_s + 4'(req_i[p]);
    end
    last_d     = xfer_s ? gidx_s : last_q;
    conflict_d = (!rst_i && (req_cnt_s >= 4'd2)) ? (conflict_q + 32'd1) : conflict_q;
  end

  // Arbiter pointer and conflict counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q     <= LAST_RST;
      conflict_q <= 32'd0;
    end else begin
      last_q     <= last_d;
      conflict_q <= conflict_d;
    end
  end

  assign conflict_o = conflict_q;

endmodule

// File: tb/tb_biriscv_mem_arbiter.sv
// tb_biriscv_mem_arbiter
// Drives two arbiters from the same request stream: one with LATENCY=1 and one
// with LATENCY=3, both with 2 ports. A reference model built from per-port
// request queues, an associative-array memory and a round-robin pointer
// predicts every grant and every response. Expected responses are queued with
// the cycle they are due. Independent monitors pop them and compare.

module tb_biriscv_mem_arbiter;

  localparam int NP = 2;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } txn_t;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        err;
    int          due;
  } rsp_t;

  bit          clk;
  logic        rst_i;
  logic [1:0]  req_i, we_i;
  logic [63:0] addr_i, wdata_i;
  logic [7:0]  be_i;
  logic [1:0]  gnt1, rv1, er1, gnt3, rv3, er3;
  logic [63:0] rd1, rd3;
  logic [31:0] cf1, cf3;

  int          cyc;
  int          checks;
  int          errors;
  logic        rst_req;
  int          last_m;
  int          last_g;
  int          exp_conf;
  txn_t        sq [NP][$];
  rsp_t        exp1 [$];
  rsp_t        exp3 [$];
  logic [31:0] mem_m [int];

  biriscv_mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(20), .DATA_WIDTH(32), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt1), .rvalid_o(rv1), .rdata_o(rd1),
    .err_o(er1), .conflict_o(cf1));

  biriscv_mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(20), .DATA_WIDTH(32), .LATENCY(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt3), .rvalid_o(rv3), .rdata_o(rd3),
    .err_o(er3), .conflict_o(cf3));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endfunction

  function automatic txn_t mk(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d; t.be = be;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.addr  = 32'h100 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
    if ($urandom_range(0, 9) == 0) t.addr[31:22] = 10'($urandom_range(1, 1023));
    t.we    = 1'($urandom_range(0, 1));
    t.wdata = $urandom;
    t.be    = 4'($urandom_range(0, 15));
    return t;
  endfunction

  // One clock of stimulus plus reference-model update
  task automatic step();
    int          g;
    int          npend;
    int          p;
    logic [1:0]  exp_g;
    txn_t        t;
    rsp_t        r;
    logic [31:0] w;
    int          idx;
    @(posedge clk);
    #1;
    rst_i = rst_req;
    for (int q = 0; q < NP; q++) begin
      if (sq[q].size() > 0) begin
        req_i[q]          = 1'b1;
        we_i[q]           = sq[q][0].we;
        addr_i[q*32 +: 32]  = sq[q][0].addr;
        wdata_i[q*32 +: 32] = sq[q][0].wdata;
        be_i[q*4 +: 4]      = sq[q][0].be;
      end else begin
        req_i[q]          = 1'b0;
        we_i[q]           = 1'($urandom_range(0, 1));
        addr_i[q*32 +: 32]  = $urandom;
        wdata_i[q*32 +: 32] = $urandom;
        be_i[q*4 +: 4]      = 4'($urandom_range(0, 15));
      end
    end
    @(negedge clk);
    chk("conflict_L1", {32'd0, cf1}, {32'd0, exp_conf});
    chk("conflict_L3", {32'd0, cf3}, {32'd0, exp_conf});
    npend = 0;
    for (int q = 0; q < NP; q++) if (sq[q].size() > 0) npend++;
    g = -1;
    if (!rst_i) begin
      for (int j = 1; j <= NP; j++) begin
        p = (last_m + j) % NP;
        if (g < 0 && sq[p].size() > 0) g = p;
      end
    end
    exp_g = 2'b00;
    if (g >= 0) exp_g[g] = 1'b1;
    chk("gnt_L1", {62'd0, gnt1}, {62'd0, exp_g});
    chk("gnt_L3", {62'd0, gnt3}, {62'd0, exp_g});
    last_g = g;
    if (g >= 0) begin
      t = sq[g].pop_front();
      r.port = g; r.data = 32'd0; r.err = 1'b0;
      idx = int'(t.addr[21:2]);
      if (t.addr[31:22] != 10'd0) begin
        r.err = 1'b1;
      end else if (t.we) begin
        w = mem_m.exists(idx) ? mem_m[idx] : 32'd0;
        for (int b = 0; b < 4; b++) if (t.be[b]) w[b*8 +: 8] = t.wdata[b*8 +: 8];
        mem_m[idx] = w;
      end else begin
        r.data = mem_m[idx];
      end
      r.due = cyc + 1; exp1.push_back(r);
      r.due = cyc + 3; exp3.push_back(r);
      last_m = g;
    end
    if (rst_i) begin
      last_m   = NP - 1;
      exp_conf = 0;
      while (exp1.size() > 0 && exp1[$].due > cyc) void'(exp1.pop_back());
      while (exp3.size() > 0 && exp3[$].due > cyc) void'(exp3.pop_back());
    end else if (npend >= 2) begin
      exp_conf++;
    end
  endtask

  // Compare one DUT's response outputs with the response due this cycle, if any
  task automatic mon(input int which, input logic [1:0] rv, input logic [63:0] rd, input logic [1:0] er);
    rsp_t        e;
    logic        hit;
    logic [1:0]  xrv, xer;
    logic [63:0] xrd;
    hit = 1'b0; xrv = 2'b00; xer = 2'b00; xrd = 64'd0;
    if (which == 1) begin
      if (exp1.size() > 0 && exp1[0].due == cyc) begin e = exp1.pop_front(); hit = 1'b1; end
    end else begin
      if (exp3.size() > 0 && exp3[0].due == cyc) begin e = exp3.pop_front(); hit = 1'b1; end
    end
    if (hit) begin
      xrv[e.port]          = 1'b1;
      xer[e.port]          = e.err;
      xrd[e.port*32 +: 32] = e.data;
    end
    chk($sformatf("rvalid_L%0d", which), {62'd0, rv}, {62'd0, xrv});
    chk($sformatf("rdata_L%0d", which), rd, xrd);
    chk($sformatf("err_L%0d", which), {62'd0, er}, {62'd0, xer});
  endtask

  always @(negedge clk) if (cyc > 0) mon(1, rv1, rd1, er1);
  always @(negedge clk) if (cyc > 0) mon(3, rv3, rd3, er3);

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((sq[0].size() + sq[1].size() + exp1.size() + exp3.size()) > 0 && k < 300) begin
      step();
      k++;
    end
    step();
    checks++;
    if ((sq[0].size() + sq[1].size() + exp1.size() + exp3.size()) != 0) begin
      errors++;
      $display("FAIL drain_%s: %0d items still outstanding, required 0", tag,
               sq[0].size() + sq[1].size() + exp1.size() + exp3.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1; rst_req = 1'b1;
    req_i = 2'b00; we_i = 2'b00; addr_i = 64'd0; wdata_i = 64'd0; be_i = 8'd0;
    cyc = 0; checks = 0; errors = 0; last_m = NP - 1; last_g = -1; exp_conf = 0;

    // Reset with requests pending: no grants, outputs idle
    sq[1].push_back(mk(1'b1, 32'h104, 32'h0BAD_F00D, 4'hF));
    repeat (3) step();
    rst_req = 1'b0;

    // Write then read back through port 0
    sq[0].push_back(mk(1'b1, 32'h100, 32'hDEADBEEF, 4'hF));
    sq[0].push_back(mk(1'b0, 32'h100, 32'h0, 4'h0));
    drain("t1");

    // Byte strobes
    sq[0].push_back(mk(1'b1, 32'h100, 32'h11223344, 4'hF));
    sq[0].push_back(mk(1'b1, 32'h102, 32'hAABBCCDD, 4'h5));
    sq[0].push_back(mk(1'b0, 32'h101, 32'h0, 4'h0));
    drain("t2");

    // Fill the rest of the working set
    for (int k = 1; k < 16; k++) sq[1].push_back(mk(1'b1, 32'h100 + 32'(k * 4), $urandom, 4'hF));
    drain("init");

    // Both ports contend continuously
    for (int k = 0; k < 4; k++) begin
      sq[0].push_back(mk(1'b0, 32'h100 + 32'(k * 4), 32'h0, 4'h0));
      sq[1].push_back(mk(1'b0, 32'h120 + 32'(k * 4), 32'h0, 4'h0));
    end
    drain("t3");

    // Out-of-range read and write; the write aliases word 0x100 if decoded wrongly
    sq[0].push_back(mk(1'b0, 32'h0040_0000, 32'h0, 4'h0));
    sq[1].push_back(mk(1'b1, 32'h0040_0100, 32'hFFFF_FFFF, 4'hF));
    sq[0].push_back(mk(1'b0, 32'h100, 32'h0, 4'h0));
    drain("t4");

    // Back-to-back reads from one port
    for (int k = 0; k < 4; k++) sq[0].push_back(mk(1'b0, 32'h104 + 32'(k * 4), 32'h0, 4'h0));
    drain("t5");

    // Reset one cycle after a grant, then contend again
    sq[0].push_back(mk(1'b0, 32'h108, 32'h0, 4'h0));
    last_g = -1;
    for (int k = 0; k < 10 && last_g != 0; k++) step();
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    sq[0].push_back(mk(1'b0, 32'h100, 32'h0, 4'h0));
    sq[1].push_back(mk(1'b0, 32'h10C, 32'h0, 4'h0));
    drain("t6");

    // Random traffic with one reset in the middle
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 1) == 1 && sq[p].size() < 2) sq[p].push_back(rand_txn());
      end
      rst_req = (i == 250) ? 1'b1 : 1'b0;
      step();
    end
    rst_req = 1'b0;
    drain("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
